// File: rtl/noc_pkg.sv
// Shared NoC definitions: header layout, receive deframer states and a saturating counter helper.
package noc_pkg;

  localparam int NOC_HDR_DST_MSB = 31;
  localparam int NOC_HDR_DST_LSB = 24;
  localparam int NOC_HDR_SRC_MSB = 23;
  localparam int NOC_HDR_SRC_LSB = 16;
  localparam int NOC_HDR_LEN_MSB = 15;
  localparam int NOC_HDR_LEN_LSB = 0;

  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [15:0] len;
  } noc_hdr_t;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PAY   = 2'd1,
    DRAIN = 2'd2
  } rx_deframer_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/noc_out_reg.sv
// One-entry registered AXI-Stream slice; accepts a new beat in the same cycle the held one drains.
module noc_out_reg #(
  parameter int W  = 32,
  parameter int KW = W / 8
) (
  input  logic          clk_out,
  input  logic          clk_out_rst_high,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic [KW-1:0] in_keep,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_last,
  input  logic          out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // Holding register: load on handshake, otherwise empty once the consumer takes the beat.
  always_ff @(posedge clk_out or posedge clk_out_rst_high) begin
    if (clk_out_rst_high) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_rx_deframer.sv
// Receive NoC deframer: decodes the header word to sideband and forwards the payload beats.
// Build option NOC_RX_LEN_CHECK_EN enforces hdr_len against the TLAST framing.
module noc_rx_deframer
  import noc_pkg::*;
#(
  parameter int BW    = 32,
  parameter int BWB   = BW / 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_out,
  input  logic             clk_out_rst_high,
  input  logic             stream_in_TVALID,
  input  logic [BW-1:0]    stream_in_TDATA,
  input  logic [BWB-1:0]   stream_in_TKEEP,
  input  logic             stream_in_TLAST,
  output logic             stream_in_TREADY,
  output logic             stream_out_TVALID,
  output logic [BW-1:0]    stream_out_TDATA,
  output logic [BWB-1:0]   stream_out_TKEEP,
  output logic             stream_out_TLAST,
  input  logic             stream_out_TREADY,
  output logic             hdr_valid,
  output logic [7:0]       hdr_dst,
  output logic [7:0]       hdr_src,
  output logic [15:0]      hdr_len,
  output logic             len_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [7:0]       err_count
);

`ifdef NOC_RX_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_deframer_state_e state_r;
  logic [15:0] beat_cnt_r;
  logic [15:0] beat_num_s;
  noc_hdr_t    hdr_s;
  logic        slot_ready_s;
  logic        in_ready_s;
  logic        fire_s;
  logic        load_s;
  logic        load_last_s;
  logic        short_s;
  logic        over_s;
  logic        hdr_err_s;

  // Header decode, length-rule evaluation and per-state input readiness.
  always_comb begin
    hdr_s.dst   = stream_in_TDATA[NOC_HDR_DST_MSB:NOC_HDR_DST_LSB];
    hdr_s.src   = stream_in_TDATA[NOC_HDR_SRC_MSB:NOC_HDR_SRC_LSB];
    hdr_s.len   = stream_in_TDATA[NOC_HDR_LEN_MSB:NOC_HDR_LEN_LSB];
    beat_num_s  = beat_cnt_r + 16'd1;
    short_s     = LEN_CHECK & stream_in_TLAST & (beat_num_s < hdr_len);
    over_s      = LEN_CHECK & ~stream_in_TLAST & (beat_num_s == hdr_len);
    hdr_err_s   = LEN_CHECK & (stream_in_TLAST ? (hdr_s.len != 16'd0) : (hdr_s.len == 16'd0));
    load_last_s = stream_in_TLAST | over_s;
    case (state_r)
      PAY:     in_ready_s = slot_ready_s;
      default: in_ready_s = 1'b1;
    endcase
  end

  assign stream_in_TREADY = in_ready_s & ~clk_out_rst_high;
  assign fire_s           = stream_in_TVALID & stream_in_TREADY;
  assign load_s           = fire_s & (state_r == PAY);

  // Framing FSM with registered sideband, error pulse and counters.
  always_ff @(posedge clk_out or posedge clk_out_rst_high) begin
    if (clk_out_rst_high) begin
      state_r    <= HDR;
      beat_cnt_r <= 16'd0;
      hdr_valid  <= 1'b0;
      hdr_dst    <= 8'd0;
      hdr_src    <= 8'd0;
      hdr_len    <= 16'd0;
      len_err    <= 1'b0;
      pkt_count  <= '0;
      err_count  <= 8'd0;
    end else begin
      hdr_valid <= 1'b0;
      len_err   <= 1'b0;
      if (fire_s) begin
        case (state_r)
          HDR: begin
            hdr_dst    <= hdr_s.dst;
            hdr_src    <= hdr_s.src;
            hdr_len    <= hdr_s.len;
            hdr_valid  <= 1'b1;
            beat_cnt_r <= 16'd0;
            if (hdr_err_s) begin
              len_err   <= 1'b1;
              err_count <= sat_inc8(err_count);
            end
            if (stream_in_TLAST) begin
              pkt_count <= pkt_count + CNT_ONE;
              state_r   <= HDR;
            end else if (hdr_err_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= PAY;
            end
          end
          PAY: begin
            beat_cnt_r <= beat_num_s;
            if (short_s || over_s) begin
              len_err   <= 1'b1;
              err_count <= sat_inc8(err_count);
            end
            if (stream_in_TLAST) begin
              pkt_count <= pkt_count + CNT_ONE;
              state_r   <= HDR;
            end else if (over_s) begin
              state_r <= DRAIN;
            end
          end
          DRAIN: begin
            if (stream_in_TLAST) begin
              pkt_count <= pkt_count + CNT_ONE;
              state_r   <= HDR;
            end
          end
          default: state_r <= HDR;
        endcase
      end
    end
  end

  noc_out_reg #(
    .W  (BW),
    .KW (BWB)
  ) u_out_reg (
    .clk_out          (clk_out),
    .clk_out_rst_high (clk_out_rst_high),
    .in_valid         (load_s),
    .in_data          (stream_in_TDATA),
    .in_keep          (stream_in_TKEEP),
    .in_last          (load_last_s),
    .in_ready         (slot_ready_s),
    .out_valid        (stream_out_TVALID),
    .out_data         (stream_out_TDATA),
    .out_keep         (stream_out_TKEEP),
    .out_last         (stream_out_TLAST),
    .out_ready        (stream_out_TREADY)
  );

endmodule
